// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Define REGFILE_WB_ARBITER_STATS_EN to add per-source grant and conflict statistics counters.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_stall,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  i_req_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_wr_en,
  output logic [SEL_WIDTH-1:0]          o_wr_sel,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
`ifdef REGFILE_WB_ARBITER_STATS_EN
  input  logic                          i_stats_clr,
  output logic [NUM_REQ*16-1:0]         o_grant_count,
  output logic [15:0]                   o_conflict_count,
`endif
  output logic                          o_conflict
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_wr_en;
  logic [SEL_WIDTH-1:0]  r_wr_sel;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_conflict;

  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic [SEL_WIDTH-1:0]  w_gnt_sel;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_multi;

  // Scan offsets from the far end so the lowest offset from r_rr_ptr wins.
  always_comb begin : arb
    int         idx;
    logic [PTR_W-1:0] idx_p;
    idx       = 0;
    idx_p     = '0;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    if (!i_rst && !i_stall) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_p = PTR_W'(idx);
        if (i_req_valid[idx_p]) begin
          w_any     = 1'b1;
          w_gnt_idx = idx_p;
        end
      end
      if (w_any) w_grant[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_gnt_sel  = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_sel  = i_req_sel[i*SEL_WIDTH +: SEL_WIDTH];
        w_gnt_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_multi     = ($countones(i_req_valid) > 1);
  assign o_req_ready = w_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_any) begin
        r_rr_ptr  <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_wr_en   <= (w_gnt_sel != '0);
        r_wr_sel  <= w_gnt_sel;
        r_wr_data <= w_gnt_data;
      end else begin
        r_wr_en   <= 1'b0;
      end
      if (!i_stall) r_conflict <= w_multi;
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_sel   = r_wr_sel;
  assign o_wr_data  = r_wr_data;
  assign o_conflict = r_conflict;

`ifdef REGFILE_WB_ARBITER_STATS_EN
  logic [15:0] r_conflict_count;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    logic [15:0] r_gcnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                              r_gcnt <= '0;
      else if (i_stats_clr)                   r_gcnt <= '0;
      else if (w_grant[g] && r_gcnt != 16'hFFFF) r_gcnt <= r_gcnt + 16'd1;
    end
    assign o_grant_count[g*16 +: 16] = r_gcnt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_conflict_count <= '0;
    else if (i_stats_clr)
      r_conflict_count <= '0;
    else if (!i_stall && w_multi && r_conflict_count != 16'hFFFF)
      r_conflict_count <= r_conflict_count + 16'd1;
  end

  assign o_conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural round-robin model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    valid;
  logic [N*SW-1:0] sel;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ready;
  logic            wr_en;
  logic [SW-1:0]   wr_sel;
  logic [DW-1:0]   wr_data;
  logic            conflict;
`ifdef REGFILE_WB_ARBITER_STATS_EN
  logic            stats_clr;
  logic [N*16-1:0] grant_count;
  logic [15:0]     conflict_count;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_req_valid(valid), .i_req_sel(sel), .i_req_data(data),
    .o_req_ready(ready), .o_wr_en(wr_en), .o_wr_sel(wr_sel), .o_wr_data(wr_data),
`ifdef REGFILE_WB_ARBITER_STATS_EN
    .i_stats_clr(stats_clr), .o_grant_count(grant_count), .o_conflict_count(conflict_count),
`endif
    .o_conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state
  int            m_ptr;
  bit            m_en;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;
  bit            m_conf;
  int            m_gcnt [N];
  int            m_ccnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_idx();
    if (rst || stall) return -1;
    for (int k = 0; k < N; k++)
      if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] one;
    g = exp_idx();
    one = 1;
    return (g < 0) ? '0 : (one << g);
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_en = 0; m_sel = '0; m_data = '0; m_conf = 0; m_ccnt = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endtask

  task automatic model_upd();
    int g;
    if (rst) return;
    g = exp_idx();
`ifdef REGFILE_WB_ARBITER_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      m_ccnt = 0;
    end else begin
      if (g >= 0 && m_gcnt[g] < 65535) m_gcnt[g]++;
      if (!stall && $countones(valid) > 1 && m_ccnt < 65535) m_ccnt++;
    end
`endif
    if (g >= 0) begin
      m_sel  = sel[g*SW +: SW];
      m_data = data[g*DW +: DW];
      m_en   = (m_sel != 0);
      m_ptr  = (g + 1) % N;
    end else begin
      m_en = 0;
    end
    if (!stall) m_conf = ($countones(valid) > 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 64'(ready), 64'(exp_ready()));
      check("wr_en", 64'(wr_en), 64'(m_en));
      check("wr_sel", 64'(wr_sel), 64'(m_sel));
      check("wr_data", 64'(wr_data), 64'(m_data));
      check("conflict", 64'(conflict), 64'(m_conf));
`ifdef REGFILE_WB_ARBITER_STATS_EN
      for (int i = 0; i < N; i++) check("grant_count", 64'(grant_count[i*16 +: 16]), 64'(m_gcnt[i]));
      check("conflict_count", 64'(conflict_count), 64'(m_ccnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    model_upd();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    step();
    #2 rst = 1'b0;
  endtask

  logic [N-1:0] rr_order [6];
  logic [SW-1:0] rr_sel [6];

  initial begin
    rst = 1'b1; stall = 1'b0; valid = '0; sel = '0; data = '0;
`ifdef REGFILE_WB_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    m_reset();
    step();
    chk_en = 1'b1;
    step();
    #2 rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_wr_en", 64'(wr_en), 64'd0);
      check("idle_ready", 64'(ready), 64'd0);
    end

    // Single write
    valid = 3'b001; sel[3:0] = 4'd5; data[31:0] = 32'hDEADBEEF;
    #1 check("single_ready", 64'(ready), 64'b001);
    step();
    valid = '0;
    check("single_wr_en", 64'(wr_en), 64'd1);
    check("single_wr_sel", 64'(wr_sel), 64'd5);
    check("single_wr_data", 64'(wr_data), 64'hDEADBEEF);

    // Round-robin from pointer 0
    do_reset();
    rr_order[0] = 3'b001; rr_order[1] = 3'b010; rr_order[2] = 3'b100;
    rr_order[3] = 3'b001; rr_order[4] = 3'b010; rr_order[5] = 3'b100;
    rr_sel[0] = 4'd1; rr_sel[1] = 4'd2; rr_sel[2] = 4'd3;
    rr_sel[3] = 4'd1; rr_sel[4] = 4'd2; rr_sel[5] = 4'd3;
    valid = 3'b111;
    sel = {4'd3, 4'd2, 4'd1};
    data = {32'hC, 32'hB, 32'hA};
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_ready", 64'(ready), 64'(rr_order[i]));
      step();
      check("rr_wr_sel", 64'(wr_sel), 64'(rr_sel[i]));
      check("rr_conflict", 64'(conflict), 64'd1);
    end

    // r0 write consumed but not issued
    valid = 3'b010; sel[7:4] = 4'd0; data[63:32] = 32'h12345678;
    #1 check("r0_ready", 64'(ready), 64'b010);
    step();
    check("r0_wr_en", 64'(wr_en), 64'd0);
    valid = 3'b111;
    #1 check("r0_ptr_adv", 64'(ready), 64'b100);
    valid = '0;
    step();

    // Stall with two sources pending (pointer is at 2)
    valid = 3'b011; sel = {4'd9, 4'd7, 4'd6}; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_ready", 64'(ready), 64'd0);
      step();
      check("stall_wr_en", 64'(wr_en), 64'd0);
    end
    stall = 1'b0;
    #1 check("unstall_g0", 64'(ready), 64'b001);
    step();
    #1 check("unstall_g1", 64'(ready), 64'b010);
    step();
    valid = '0;
    step();

    // Async reset mid-stream
    valid = 3'b001; sel[3:0] = 4'd5;
    step();
    valid = '0;
    check("pre_rst_wr_en", 64'(wr_en), 64'd1);
    #2 rst = 1'b1;
    m_reset();
    #1 check("async_rst_wr_en", 64'(wr_en), 64'd0);
    check("async_rst_ready", 64'(ready), 64'd0);
    step();
    #1 rst = 1'b0;
    valid = 3'b111; sel = {4'd3, 4'd2, 4'd1};
    #1 check("post_rst_g0", 64'(ready), 64'b001);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      valid = N'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        sel[i*SW +: SW]  = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
        data[i*DW +: DW] = $urandom;
      end
`ifdef REGFILE_WB_ARBITER_STATS_EN
      stats_clr = ($urandom_range(0, 99) == 0);
`endif
      step();
    end
    valid = '0; stall = 1'b0;
`ifdef REGFILE_WB_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    step();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
